// File: rtl/seq_shr33.sv
// Multi-cycle right shifter: consumes up to 3 bit positions per cycle through one 4:1 mux stage.
// Logical (zero fill) or arithmetic (sign fill); result registered and held until the next start.
module seq_shr33 #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned SHW   = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_arith,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       step;
    logic             fill;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   rem_next;

    // Single mux stage: shift by 0..3 with the selected fill bit.
    always_comb begin
        step     = (rem_q >= SHW'(3)) ? 2'd3 : rem_q[1:0];
        fill     = arith_q & acc_q[WIDTH-1];
        rem_next = rem_q - SHW'(step);
        shifted  = acc_q;
        unique case (step)
            2'd0: shifted = acc_q;
            2'd1: shifted = {fill, acc_q[WIDTH-1:1]};
            2'd2: shifted = {{2{fill}}, acc_q[WIDTH-1:2]};
            2'd3: shifted = {{3{fill}}, acc_q[WIDTH-1:3]};
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        arith_d = arith_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    acc_d   = d_in;
                    rem_d   = shamt;
                    arith_d = op_arith;
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    dout_d  = shifted;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        // Status flags are registered copies of the next state, so outputs carry no comb path.
        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
            arith_q <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            arith_q <= arith_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d_out = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
